// File: rtl/gs232c_pht.sv
// Gshare pattern history table: 2-bit saturating counters indexed by PC xor branch history,
// trained through a one-entry write buffer and initialised by a sweep after reset or clear.
module gs232c_pht #(
    parameter int         IDXW     = 8,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        pht_clear,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    input  logic [20:0] hr_bt,
    input  logic        up_valid,
    input  logic [31:0] up_pc,
    input  logic [24:0] hr_br,
    output logic        pht_ready,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [1:0]  pred_cnt
);

    localparam int DEPTH = 1 << IDXW;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state;
    logic [IDXW-1:0]   ptr;
    logic [1:0]        cnt_mem [DEPTH];

    logic              wb_valid;
    logic [IDXW-1:0]   wb_idx;
    logic              wb_taken;

    logic [IDXW-1:0]   lidx;
    logic [IDXW-1:0]   uidx;
    logic [1:0]        wb_old;
    logic [1:0]        wb_new;
    logic [1:0]        lk_cnt;

    assign lidx   = lk_pc[IDXW+1:2] ^ hr_bt[IDXW-1:0];
    assign uidx   = up_pc[IDXW+1:2] ^ hr_br[IDXW:1];
    assign wb_old = cnt_mem[wb_idx];

    // The array write lands at the end of the RMW cycle, so the next RMW reads the fresh value.
    always_comb begin
        wb_new = wb_old;
        if (wb_taken) begin
            if (wb_old != 2'b11) begin
                wb_new = wb_old + 2'b01;
            end
        end else begin
            if (wb_old != 2'b00) begin
                wb_new = wb_old - 2'b01;
            end
        end
    end

    // A lookup hitting the entry being written this cycle must see the trained value.
    always_comb begin
        lk_cnt = cnt_mem[lidx];
        if (wb_valid && (wb_idx == lidx)) begin
            lk_cnt = wb_new;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_INIT;
            ptr        <= '0;
            pht_ready  <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_cnt   <= 2'b00;
            wb_valid   <= 1'b0;
            wb_idx     <= '0;
            wb_taken   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    pred_valid <= 1'b0;
                    wb_valid   <= 1'b0;
                    if (pht_clear) begin
                        ptr <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                        if (&ptr) begin
                            state     <= ST_RUN;
                            pht_ready <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    pred_valid <= lk_valid;
                    if (lk_valid) begin
                        pred_cnt   <= lk_cnt;
                        pred_taken <= lk_cnt[1];
                    end
                    if (pht_clear) begin
                        state     <= ST_INIT;
                        ptr       <= '0;
                        pht_ready <= 1'b0;
                        wb_valid  <= 1'b0;
                    end else begin
                        wb_valid <= up_valid;
                        if (up_valid) begin
                            wb_idx   <= uidx;
                            wb_taken <= hr_br[0];
                        end
                    end
                end
                default: begin
                    state <= ST_INIT;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Storage is deliberately unreset; the sweep is the only initialisation path.
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            cnt_mem[ptr] <= INIT_CNT;
        end else if (wb_valid) begin
            cnt_mem[wb_idx] <= wb_new;
        end
    end

endmodule

// File: tb/tb_gs232c_pht.sv
// Randomised scoreboard bench for gs232c_pht against a table-of-integers reference model.
module tb_gs232c_pht;

    localparam int IDXW  = 8;
    localparam int DEPTH = 1 << IDXW;

    logic        clock = 1'b0;
    logic        resetn;
    logic        pht_clear;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic [20:0] hr_bt;
    logic        up_valid;
    logic [31:0] up_pc;
    logic [24:0] hr_br;
    logic        pht_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_cnt;

    int checks = 0;
    int fails  = 0;
    int model [DEPTH];
    int init_left = 0;
    int exp_q [$];
    int last_exp = 0;

    gs232c_pht #(.IDXW(IDXW), .INIT_CNT(2'b01)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pht_clear  (pht_clear),
        .lk_valid   (lk_valid),
        .lk_pc      (lk_pc),
        .hr_bt      (hr_bt),
        .up_valid   (up_valid),
        .up_pc      (up_pc),
        .hr_br      (hr_br),
        .pht_ready  (pht_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_cnt   (pred_cnt)
    );

    always #5 clock = ~clock;

    function automatic int tableIdx(logic [31:0] pc, logic [31:0] hist);
        logic [31:0] v;
        v = ((pc / 32'd4) ^ hist) % 32'(DEPTH);
        return int'(v);
    endfunction

    task automatic checkOutput(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour, applied to the reference table.
    task automatic modelStep(bit lkv, logic [31:0] lkpc, logic [20:0] hbt,
                             bit upv, logic [31:0] uppc, logic [24:0] hbr, bit clr);
        int i;
        if (init_left > 0) begin
            init_left = clr ? DEPTH : init_left - 1;
        end else if (clr) begin
            init_left = DEPTH;
            for (int k = 0; k < DEPTH; k++) model[k] = 1;
        end else begin
            if (lkv) exp_q.push_back(model[tableIdx(lkpc, 32'(hbt))]);
            if (upv) begin
                i = tableIdx(uppc, 32'(hbr) / 32'd2);
                if (hbr[0]) model[i] = (model[i] == 3) ? 3 : model[i] + 1;
                else        model[i] = (model[i] == 0) ? 0 : model[i] - 1;
            end
        end
    endtask

    task automatic applyStimulus(bit lkv, logic [31:0] lkpc, logic [20:0] hbt,
                                 bit upv, logic [31:0] uppc, logic [24:0] hbr, bit clr);
        @(posedge clock);
        #1;
        checkOutput("pht_ready", int'(pht_ready), (init_left == 0) ? 1 : 0);
        lk_valid  = lkv;
        lk_pc     = lkpc;
        hr_bt     = hbt;
        up_valid  = upv;
        up_pc     = uppc;
        hr_br     = hbr;
        pht_clear = clr;
        modelStep(lkv, lkpc, hbt, upv, uppc, hbr, clr);
    endtask

    // Small index range keeps aliasing and same-entry back-to-back updates frequent.
    task automatic randomCycle();
        logic [31:0] lpc, upc;
        logic [20:0] hbt;
        logic [24:0] hbr;
        lpc = {$urandom_range(0, 32'h3FFFFF), 3'($urandom_range(0, 7)) , 5'b0, 2'($urandom_range(0, 3))};
        lpc[9:2] = 8'($urandom_range(0, 7));
        upc = $urandom;
        upc[9:2] = 8'($urandom_range(0, 7));
        hbt = 21'($urandom);
        hbt[7:0] = 8'($urandom_range(0, 7));
        hbr = 25'($urandom);
        hbr[8:1] = 8'($urandom_range(0, 7));
        applyStimulus(1'($urandom_range(0, 1)), lpc, hbt, 1'($urandom_range(0, 1)), upc, hbr, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b0, 32'h0, 25'h0, 1'b0);
    endtask

    task automatic waitReady();
        for (int n = 0; n < 4 * DEPTH && init_left > 0; n++) randomCycle();
        checkOutput("sweep bound", init_left, 0);
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (pred_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected pred_valid", 1, 0);
                end else begin
                    last_exp = exp_q.pop_front();
                    checkOutput("pred_cnt", int'(pred_cnt), last_exp);
                    checkOutput("pred_taken", int'(pred_taken), last_exp / 2);
                end
            end else begin
                checkOutput("pred_cnt hold", int'(pred_cnt), last_exp);
            end
        end
    end

    initial begin
        resetn = 1'b0;
        pht_clear = 1'b0; lk_valid = 1'b0; lk_pc = '0; hr_bt = '0;
        up_valid = 1'b0; up_pc = '0; hr_br = '0;
        for (int k = 0; k < DEPTH; k++) model[k] = 1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset pht_ready", int'(pht_ready), 0);
        checkOutput("reset pred_valid", int'(pred_valid), 0);
        checkOutput("reset pred_taken", int'(pred_taken), 0);
        checkOutput("reset pred_cnt", int'(pred_cnt), 0);
        resetn = 1'b1;
        init_left = DEPTH;
        modelStep(1'b0, 32'h0, 21'h0, 1'b0, 32'h0, 25'h0, 1'b0);

        // Lookups and updates during the sweep must be ignored.
        waitReady();
        repeat (8) applyStimulus(1'b1, 32'($urandom), 21'($urandom), 1'b0, 32'h0, 25'h0, 1'b0);

        applyStimulus(1'b1, 32'h40, 21'h0, 1'b0, 32'h0, 25'h0, 1'b0);
        idle();
        repeat (3) begin
            applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'h40, 25'h1, 1'b0);
            applyStimulus(1'b1, 32'h40, 21'h0, 1'b0, 32'h0, 25'h0, 1'b0);
        end
        repeat (4) begin
            applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'h40, 25'h0, 1'b0);
            applyStimulus(1'b1, 32'h40, 21'h0, 1'b0, 32'h0, 25'h0, 1'b0);
        end

        applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'h14, 25'h1, 1'b0);
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'h14, 25'h1, 1'b0);
        applyStimulus(1'b1, 32'h14, 21'h0, 1'b0, 32'h0, 25'h0, 1'b0);
        applyStimulus(1'b1, 32'h0, 21'h5, 1'b0, 32'h0, 25'h0, 1'b0);
        idle();

        applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'h14, 25'h0, 1'b1);
        repeat (100) randomCycle();
        applyStimulus(1'b0, 32'h0, 21'h0, 1'b0, 32'h0, 25'h0, 1'b1);
        waitReady();
        applyStimulus(1'b1, 32'h14, 21'h0, 1'b0, 32'h0, 25'h0, 1'b0);
        idle();

        for (int n = 0; n < 600; n++) begin
            if (n == 300) applyStimulus(1'b0, 32'h0, 21'h0, 1'b1, 32'($urandom), 25'($urandom), 1'b1);
            else          randomCycle();
        end
        repeat (3) idle();
        checkOutput("pending predictions", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/gs232c_pht.md
Name: gs232c_pht

Overview:
- Gshare pattern history table; the direct consumer of the branch history register outputs.
- Lookup path: fetch PC XOR hr_bt selects a 2-bit saturating counter; the taken/not-taken prediction is registered one cycle later.
- Update path: resolved branches arrive with PC and hr_br (history in bits [24:1], own outcome in bit 0). They train the counter through a one-entry write buffer with read-after-write bypass.
- After reset, or on request, a sweep FSM initialises every entry to weakly-not-taken.

Parameters:
- IDXW, 8, index width; table holds 2^IDXW counters (IDXW ≤ 20).
- INIT_CNT, 2'b01, counter value written by the init sweep.

Ports:
- clock  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- pht_clear  in  1  one-cycle pulse: restart the init sweep
- lk_valid  in  1  lookup request this cycle
- lk_pc  in  32  fetch PC of the lookup
- hr_bt  in  21  speculative history from the BHR
- up_valid  in  1  resolved conditional branch this cycle
- up_pc  in  32  PC of the resolved branch
- hr_br  in  25  {history used at prediction, actual outcome}
- pht_ready  out  1  high when the table is usable (not initialising)
- pred_valid  out  1  prediction valid (one cycle after lk_valid)
- pred_taken  out  1  predicted direction, equal to counter bit 1
- pred_cnt  out  2  counter value used for the prediction

Behaviour:
- Reset (async, resetn=0):
  - state=INIT, sweep pointer=0, pht_ready=0.
  - pred_valid=0, pred_taken=0, pred_cnt=0.
  - Write buffer invalid.
  - Counter array is NOT reset; the sweep initialises it.
- FSM states: INIT and RUN.
  - INIT: each cycle writes INIT_CNT to entry[ptr] and increments ptr. When ptr = 2^IDXW-1 is written, go to RUN next cycle and set pht_ready=1. Sweep takes exactly 2^IDXW cycles.
  - RUN to INIT on pht_clear: ptr=0, pht_ready=0, write buffer invalidated.
  - pht_clear during INIT restarts the sweep at ptr=0.
- Inputs ignored while in INIT:
  - lk_valid is ignored; pred_valid=0.
  - up_valid is dropped; no buffering.
- Lookup index: lidx = lk_pc[IDXW+1:2] ^ hr_bt[IDXW-1:0].
- Lookup latency: 1 cycle.
  - Cycle N+1: pred_valid=lk_valid(N), pred_cnt=counter value, pred_taken=pred_cnt[1].
  - pred_valid deasserts when there is no lookup.
  - pred_cnt/pred_taken hold their last value while pred_valid=0.
- Update index and outcome:
  - uidx = up_pc[IDXW+1:2] ^ hr_br[IDXW:1]; taken = hr_br[0].
- Update pipeline:
  - Cycle N: latch {uidx, taken} into the write buffer, marked valid.
  - Cycle N+1: read entry[uidx], saturate, write back. Taken: 3 stays 3, else +1. Not taken: 0 stays 0, else -1.
  - The buffer is re-filled the same cycle if up_valid is high again. Back-to-back updates are sustained at 1/cycle.
- Back-to-back updates to the same index: the second read-modify-write must see the first's result (forward the just-computed value). Two consecutive taken updates starting at 1 must end at 3.
- Bypass: a lookup in cycle N+1 whose lidx equals the buffered uidx returns the post-update counter value, not the stale array value.
- Simultaneous pht_clear and up_valid: the clear wins; the update is discarded.
- Index width: only the low IDXW bits of the history are used. Higher history bits are ignored.
- Never write X to the array; writes happen only from the sweep or a valid buffer.

Test Plan:
- Init sweep: resetn 0→1 with IDXW=4 → pht_ready=0 for 16 cycles, then 1. Lookup of any index → pred_cnt=01, pred_taken=0.
- Lookup latency: lk_valid=1, lk_pc=0x40, hr_bt=0 (index 0x10 with IDXW=8) → next cycle pred_valid=1, pred_cnt=01. Following idle cycle → pred_valid=0.
- Saturation up and down:
  - Three taken updates, up_pc=0x40, hr_br=25'h1 → counter goes 10, 11, 11.
  - Then four not-taken updates, hr_br=0 → counter goes 10, 01, 00, 00.
- Back-to-back plus bypass: two consecutive taken updates to index 5, followed the next cycle by a lookup of index 5 → pred_cnt=11.
- Aliasing via history: lk_pc=0x14 with hr_bt=0, versus lk_pc=0x0 with hr_bt=5 → both select index 5 and report the same counter.
- Clear mid-operation: pht_clear asserted while up_valid=1 after training index 5 to 11 → update discarded, pht_ready low for 2^IDXW cycles, then lookup of index 5 returns 01.
